clock_ratio_monitor: RTL and testbench

//  Receive-side checker for divided clocks produced from clkin (e.g. divide-by-N generators).

---
 rtl/clock_ratio_monitor.sv | 163 ++++++++++++++++
 tb/tb_clock_ratio_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_ratio_monitor.sv
// clock_ratio_monitor
// Receive-side checker for a divided clock derived from clkin. The divided
// signal is treated as data: it is synchronised, its rising edges are found,
// and the rise-to-rise period and high time are measured in clkin cycles.
// Lock is declared after LOCK_CNT consecutive periods equal expected_div;
// mismatches while locked and stalls longer than MAX_DIV cycles are flagged.
module clock_ratio_monitor #(
    parameter int MAX_DIV  = 16,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = $clog2(MAX_DIV + 1)
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             enable,
    input  logic             div_in,
    input  logic [CNT_W-1:0] expected_div,
    input  logic             clr_err,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             ratio_err,
    output logic             timeout
);

    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam logic [MC_W-1:0]  LOCK_MAX = MC_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] PCNT_MAX = CNT_W'(MAX_DIV);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } state_t;

    state_t           state_q;
    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] pcnt_q, hcnt_q;
    logic [MC_W-1:0]  match_cnt_q;
    logic [CNT_W-1:0] period_q, high_time_q;
    logic             meas_valid_q, locked_q, ratio_err_q, timeout_q;

    logic             rise;
    logic             match;
    logic [CNT_W-1:0] pcnt_d, hcnt_d;
    logic [MC_W-1:0]  match_cnt_d;

    // Saturating increment of the consecutive-match counter
    function automatic logic [MC_W-1:0] sat_inc(input logic [MC_W-1:0] v);
        if (v >= LOCK_MAX) begin
            return LOCK_MAX;
        end
        return v + MC_W'(1);
    endfunction

    // Edge detect and next-count values derived from the current registers
    always_comb begin
        rise        = s2_q & ~s3_q;
        // expected_div of 0 or beyond MAX_DIV is unreachable, so it never matches
        match       = (expected_div != '0) && (int'(expected_div) <= MAX_DIV) &&
                      (pcnt_q == expected_div);
        pcnt_d      = pcnt_q + CNT_W'(1);
        hcnt_d      = hcnt_q + CNT_W'(s2_q);
        match_cnt_d = sat_inc(match_cnt_q);
    end

    // Synchroniser, measurement FSM, lock tracking and sticky error flags
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q      <= IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            pcnt_q       <= '0;
            hcnt_q       <= '0;
            match_cnt_q  <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            ratio_err_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            s1_q         <= div_in;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            meas_valid_q <= 1'b0;

            // Clear first; any set later in this block overrides it
            if (clr_err) begin
                ratio_err_q <= 1'b0;
                timeout_q   <= 1'b0;
            end

            if (!enable) begin
                state_q     <= IDLE;
                locked_q    <= 1'b0;
                match_cnt_q <= '0;
                pcnt_q      <= '0;
                hcnt_q      <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        pcnt_q  <= '0;
                        hcnt_q  <= '0;
                        state_q <= ACQUIRE;
                    end
                    ACQUIRE: begin
                        // First rise only aligns the counters; no period yet
                        if (rise) begin
                            state_q <= TRACK;
                            pcnt_q  <= CNT_W'(1);
                            hcnt_q  <= CNT_W'(1);
                        end
                    end
                    TRACK: begin
                        if (rise) begin
                            period_q     <= pcnt_q;
                            high_time_q  <= hcnt_q;
                            meas_valid_q <= 1'b1;
                            pcnt_q       <= CNT_W'(1);
                            hcnt_q       <= CNT_W'(1);
                            if (match) begin
                                match_cnt_q <= match_cnt_d;
                                if (match_cnt_d == LOCK_MAX) begin
                                    locked_q <= 1'b1;
                                end
                            end else begin
                                match_cnt_q <= '0;
                                locked_q    <= 1'b0;
                                if (locked_q) begin
                                    ratio_err_q <= 1'b1;
                                end
                            end
                        end else if (pcnt_q == PCNT_MAX) begin
                            // Stalled divider: drop lock and re-acquire
                            timeout_q   <= 1'b1;
                            locked_q    <= 1'b0;
                            match_cnt_q <= '0;
                            pcnt_q      <= '0;
                            hcnt_q      <= '0;
                            state_q     <= ACQUIRE;
                        end else begin
                            pcnt_q <= pcnt_d;
                            hcnt_q <= hcnt_d;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign ratio_err  = ratio_err_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Bench for clock_ratio_monitor: per-cycle vector table for reset and lock
// acquisition, then hand-written pulse sequences for error, timeout, enable
// and clear corner cases.
module tb_clock_ratio_monitor;

    localparam int CNT_W = 5;

    logic             clkin = 1'b0;
    logic             reset, enable, div_in, clr_err;
    logic [CNT_W-1:0] expected_div;
    logic [CNT_W-1:0] period, high_time;
    logic             meas_valid, locked, ratio_err, timeout;

    int checks = 0;
    int errors = 0;

    clock_ratio_monitor #(.MAX_DIV(16), .LOCK_CNT(4)) dut (
        .clkin        (clkin),
        .reset        (reset),
        .enable       (enable),
        .div_in       (div_in),
        .expected_div (expected_div),
        .clr_err      (clr_err),
        .period       (period),
        .high_time    (high_time),
        .meas_valid   (meas_valid),
        .locked       (locked),
        .ratio_err    (ratio_err),
        .timeout      (timeout)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        logic             rst;
        logic             div;
        logic [CNT_W-1:0] per;
        logic [CNT_W-1:0] ht;
        logic             mv;
        logic             lk;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic div, input int per, input int ht,
                       input logic mv, input logic lk);
        vec_t v;
        v.rst = rst; v.div = div; v.per = CNT_W'(per); v.ht = CNT_W'(ht);
        v.mv = mv; v.lk = lk;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic d, input logic clr);
        div_in  = d;
        clr_err = clr;
        @(posedge clkin);
        #1;
        clr_err = 1'b0;
    endtask

    // One divided-clock period: hi cycles high then low, len cycles total.
    // Captures outputs at the meas_valid cycle (or at the end if none) and
    // the flags right after the first edge.
    task automatic pulse(input int len, input int hi, input logic clr_first,
                         output int nmv, output logic [CNT_W-1:0] per,
                         output logic [CNT_W-1:0] ht, output logic lk,
                         output logic re, output logic to,
                         output logic re1, output logic to1);
        nmv = 0; per = '0; ht = '0; lk = 1'b0; re = 1'b0; to = 1'b0;
        re1 = 1'b0; to1 = 1'b0;
        for (int i = 0; i < len; i++) begin
            step(i < hi, (i == 0) && clr_first);
            if (i == 0) begin
                re1 = ratio_err;
                to1 = timeout;
            end
            if (meas_valid) begin
                nmv++;
                per = period; ht = high_time;
                lk = locked; re = ratio_err; to = timeout;
            end
        end
        if (nmv == 0) begin
            lk = locked; re = ratio_err; to = timeout;
        end
    endtask

    int               n, mvs;
    logic [CNT_W-1:0] p, h;
    logic             lk, re, to, re1, to1;
    logic [13:0]      got, want;

    initial begin
        reset = 1'b1; enable = 1'b1; div_in = 1'b0; clr_err = 1'b0;
        expected_div = CNT_W'(3);

        // rst div period high mv locked (outputs after that edge)
        add(1, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 3, 1, 1, 0);
        add(0, 1, 3, 1, 0, 0);
        add(0, 0, 3, 1, 0, 0);
        add(0, 0, 3, 1, 1, 0);
        add(0, 1, 3, 1, 0, 0);
        add(0, 0, 3, 1, 0, 0);
        add(0, 0, 3, 1, 1, 0);
        add(0, 1, 3, 1, 0, 0);
        add(0, 0, 3, 1, 0, 0);
        add(0, 0, 3, 1, 1, 1);

        @(negedge clkin);
        foreach (tbl[i]) begin
            reset  = tbl[i].rst;
            div_in = tbl[i].div;
            @(posedge clkin);
            #1;
            got  = {period, high_time, meas_valid, locked, ratio_err, timeout};
            want = {tbl[i].per, tbl[i].ht, tbl[i].mv, tbl[i].lk, 1'b0, 1'b0};
            chk($sformatf("vec%0d", i), 32'(got), 32'(want));
        end

        // Already locked: a further match keeps lock
        pulse(3, 1, 0, n, p, h, lk, re, to, re1, to1);
        chk("sat_mv", n, 1); chk("sat_period", p, 3); chk("sat_locked", lk, 1);
        // Long period; its measurement appears in the following pulse
        pulse(4, 1, 0, n, p, h, lk, re, to, re1, to1);
        chk("pre_err_locked", lk, 1);
        pulse(3, 1, 0, n, p, h, lk, re, to, re1, to1);
        chk("err_period", p, 4); chk("err_locked", lk, 0); chk("err_ratio", re, 1);
        // Clear then relock over four matches, one with a 2-cycle high
        pulse(3, 1, 1, n, p, h, lk, re, to, re1, to1);
        chk("clr_ratio", re1, 0); chk("relock1", lk, 0); chk("relock1_period", p, 3);
        pulse(3, 2, 0, n, p, h, lk, re, to, re1, to1);
        chk("relock2", lk, 0);
        pulse(3, 1, 0, n, p, h, lk, re, to, re1, to1);
        chk("relock3", lk, 0); chk("high2", h, 2); chk("high2_period", p, 3);
        pulse(3, 1, 0, n, p, h, lk, re, to, re1, to1);
        chk("relock4", lk, 1); chk("relock4_err", re, 0);

        // div_in stuck low: timeout on the 16th cycle after the last rise
        mvs = 0;
        for (int i = 1; i <= 16; i++) begin
            step(0, 0);
            if (meas_valid) mvs++;
            if (i == 15) begin
                chk("to_early", timeout, 0); chk("to_early_lk", locked, 1);
            end
        end
        chk("to_set", timeout, 1); chk("to_locked", locked, 0); chk("to_no_mv", mvs, 0);
        // Back in ACQUIRE: first rise produces no measurement
        pulse(3, 1, 0, n, p, h, lk, re, to, re1, to1);
        chk("acq_no_mv", n, 0); chk("to_sticky", to, 1);
        pulse(3, 1, 1, n, p, h, lk, re, to, re1, to1);
        chk("clr_timeout", to1, 0); chk("acq_mv", n, 1); chk("acq_period", p, 3);
        for (int i = 0; i < 3; i++) pulse(3, 1, 0, n, p, h, lk, re, to, re1, to1);
        chk("relock_after_to", lk, 1);

        // Disable mid-period
        step(1, 0);
        enable = 1'b0;
        step(0, 0);
        chk("dis_locked", locked, 0); chk("dis_period", period, 3); chk("dis_mv", meas_valid, 0);
        mvs = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0);
            if (meas_valid) mvs++;
        end
        chk("dis_hold_period", period, 3); chk("dis_no_mv", mvs, 0);
        enable = 1'b1;
        step(0, 0);
        pulse(3, 1, 0, n, p, h, lk, re, to, re1, to1);
        chk("en_rise1_no_mv", n, 0);
        pulse(3, 1, 0, n, p, h, lk, re, to, re1, to1);
        chk("en_rise2_mv", n, 1); chk("en_rise2_lk", lk, 0);
        pulse(3, 1, 0, n, p, h, lk, re, to, re1, to1);
        pulse(3, 1, 0, n, p, h, lk, re, to, re1, to1);
        chk("en_lk3", lk, 0);
        pulse(3, 1, 0, n, p, h, lk, re, to, re1, to1);
        chk("en_lk4", lk, 1);

        // expected_div = 0: a clean stream never locks
        expected_div = '0;
        mvs = 0;
        for (int i = 0; i < 6; i++) begin
            pulse(3, 1, 0, n, p, h, lk, re, to, re1, to1);
            if (i == 0) chk("ed0_ratio_err", re, 1);
            if (lk) mvs++;
        end
        chk("ed0_never_locked", mvs, 0);
        chk("ed0_period", p, 3);

        // clr_err on the same edge that timeout sets: set wins
        for (int i = 1; i <= 16; i++) step(0, i == 16);
        chk("to_vs_clr", timeout, 1);
        step(0, 0);
        chk("to_vs_clr_hold", timeout, 1);
        step(0, 1);
        chk("to_final_clr", timeout, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
